div_operand_normalizer: RTL
===========================

Name: div_operand_normalizer

Overview:
- Upstream stage for the Newton-Raphson fractional divider.
- Accepts raw unsigned integer dividend and divisor and left-normalizes each to the 0.1xxx fraction form the divider requires.
- Reports the binary exponent correction and issues a one-cycle start to the divider.
- Quotient reconstruction downstream: a/b = (na/nb) * 2^exp.
- Zero operands are flagged and never issued to the divider.

Parameters:
- WIDTH, 32, operand width in bits; power of two ≥ 4.
- EXPW, 6, width of the signed exponent output; must hold ±(WIDTH-1).

Ports:
- clk  in  1  rising-edge clock
- clrn  in  1  asynchronous active-low reset
- start  in  1  request; sampled high while not busy → accept a, b
- a  in  WIDTH  unsigned integer dividend
- b  in  WIDTH  unsigned integer divisor
- na  out  WIDTH  normalized dividend, MSB=1 unless zero flagged
- nb  out  WIDTH  normalized divisor, MSB=1 unless dz flagged
- exp  out  EXPW  signed; zb - za, where za, zb = leading-zero counts of a, b
- busy  out  1  normalization in progress
- ready  out  1  results valid; level signal
- div_start  out  1  one-cycle pulse to divider start input
- dz  out  1  divide-by-zero (b == 0)
- zero  out  1  dividend zero (a == 0, b != 0)

Behaviour:
- Reset: async on clrn low. All outputs 0: na, nb, exp, busy, ready, div_start, dz, zero. Internal state to IDLE, step counter and lz counters to 0.
- Reset mid-operation aborts immediately; no div_start is emitted afterwards.
- States: IDLE, NORM.
- Accept: in any state with busy=0, start high at edge E:
  - latch a→na, b→nb; clear za/zb counters.
  - ready, dz, zero ← 0.
  - if b==0: dz←1, ready←1, busy stays 0, state IDLE; na, nb latched raw.
  - else if a==0: zero←1, busy←1, state NORM. Only nb normalizes; na stays 0, za contributes 0.
  - else: busy←1, state NORM, step←0.
- Start with busy=1 is ignored; inputs not re-sampled.
- NORM: one step per clock, log2(WIDTH) steps. Shift amounts WIDTH/2, WIDTH/4, …, 1 (16, 8, 4, 2, 1 at default).
  - per step, per operand independently: if the top N bits are all zero, shift left by N (zero fill) and add N to its lz count.
  - both operands step in parallel in the same cycle.
- Last step edge (E+5 at default):
  - na/nb final; exp ← zb - za (sign-extended, two's complement).
  - busy←0, ready←1, state IDLE.
  - div_start←1 only if zero=0; div_start clears the following edge.
- Latency: start edge to ready = log2(WIDTH) cycles (5); dz case = 1 cycle.
- na, nb, exp, dz, zero hold stable until the next accepted start.
- ready remains high until the next accepted start.
- Back-to-back: start high on the same edge div_start falls is accepted (busy already 0).
- Divider contract: na and nb stable from the div_start cycle onward, which satisfies the divider's latch-on-start requirement.
- exp range −(WIDTH-1)..+(WIDTH-1); no saturation needed.

Test Plan:
- a=0x00000003, b=0x00010000, start 1 cycle:
  - busy high for 5 cycles, then ready=1.
  - na=0xC0000000, nb=0x80000000, exp=-15 (0x31).
  - div_start high exactly 1 cycle, coincident with ready rising.
- a=0x80000000, b=0xFFFFFFFF → na=0x80000000, nb=0xFFFFFFFF, exp=0, ready after 5 cycles, div_start pulse.
- a=0x00000001, b=0x80000000 → na=0x80000000, exp=-31 (0x21); reverse operands → exp=+31 (0x1F).
- b=0, a=7 → dz=1 and ready=1 one cycle after start; busy never high; div_start never asserted.
- a=0, b=5 → zero=1, na=0, nb=0xA0000000, exp=29, ready after 5 cycles, div_start stays 0.
- Interrupts and back-to-back:
  - start reasserted with new operands during busy → ignored; results match first operands.
  - clrn low at step 3 → all outputs 0 immediately, no div_start after release.
  - start on the cycle after ready → new results after 5 more cycles.

Source files
------------

// File: rtl/div_operand_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_operand_normalizer_if
//  Purpose  : Handshake / data bundle between a requester and the divider
//             operand normalizer.
//  Signals  : start, a, b           requester -> normalizer
//             na, nb, exp, busy,
//             ready, div_start,
//             dz, zero              normalizer -> requester / divider
//  Revision : 1.0  initial release
// ============================================================================
interface div_operand_normalizer_if #(
  parameter int WIDTH = 32,
  parameter int EXPW  = 6
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] na;
  logic [WIDTH-1:0] nb;
  logic [EXPW-1:0]  exp;
  logic             busy;
  logic             ready;
  logic             div_start;
  logic             dz;
  logic             zero;

  modport master (
    output start, a, b,
    input  na, nb, exp, busy, ready, div_start, dz, zero
  );

  modport slave (
    input  start, a, b,
    output na, nb, exp, busy, ready, div_start, dz, zero
  );
endinterface
`default_nettype wire

// File: rtl/div_operand_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : div_operand_normalizer
//  Purpose  : Left-normalizes an unsigned dividend/divisor pair to 0.1xxx
//             fraction form for a Newton-Raphson divider, reports the
//             exponent correction (a/b = na/nb * 2^exp) and issues a
//             one-cycle start pulse. Zero operands are flagged, not issued.
//  Ports    : clk        rising-edge clock
//             clrn       asynchronous active-low reset
//             bus        slave side of div_operand_normalizer_if
//                        (start/a/b in; na/nb/exp/busy/ready/div_start/dz/zero out)
//  Revision : 1.0  initial release
// ============================================================================
module div_operand_normalizer #(
  parameter int WIDTH = 32,
  parameter int EXPW  = 6
) (
  input  wire logic               clk,
  input  wire logic               clrn,
  div_operand_normalizer_if.slave bus
);

  localparam int LOGW = $clog2(WIDTH);
  // Leading-zero counts reach at most WIDTH-1; one extra bit also holds the
  // first shift amount WIDTH/2 and the constant WIDTH used to derive it.
  localparam int LZW  = LOGW + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

  state_t           r_state;
  logic [LOGW-1:0]  r_step;
  logic [WIDTH-1:0] r_na;
  logic [WIDTH-1:0] r_nb;
  logic [LZW-1:0]   r_za;
  logic [LZW-1:0]   r_zb;
  logic [EXPW-1:0]  r_exp;
  logic             r_busy;
  logic             r_ready;
  logic             r_div_start;
  logic             r_dz;
  logic             r_zero;

  logic [LZW-1:0]   w_sh;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_na_next;
  logic [WIDTH-1:0] w_nb_next;
  logic [LZW-1:0]   w_za_next;
  logic [LZW-1:0]   w_zb_next;
  logic             w_last;

  // One binary-search step of the leading-zero count: shift amounts halve
  // each cycle (WIDTH/2 ... 1), so after log2(WIDTH) steps the MSB is set.
  always_comb begin
    w_sh      = LZW'(WIDTH) >> (r_step + LOGW'(1));
    w_mask    = ~({WIDTH{1'b1}} >> w_sh);  // top w_sh bits set
    w_na_next = r_na;
    w_za_next = r_za;
    w_nb_next = r_nb;
    w_zb_next = r_zb;
    // A zero dividend stays zero and must not contribute to the exponent.
    if (!r_zero && ((r_na & w_mask) == '0)) begin
      w_na_next = r_na << w_sh;
      w_za_next = r_za + w_sh;
    end
    if ((r_nb & w_mask) == '0) begin
      w_nb_next = r_nb << w_sh;
      w_zb_next = r_zb + w_sh;
    end
    w_last = (r_step == LOGW'(LOGW - 1));
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_na        <= '0;
      r_nb        <= '0;
      r_za        <= '0;
      r_zb        <= '0;
      r_exp       <= '0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_div_start <= 1'b0;
      r_dz        <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_div_start <= 1'b0;
      if (!r_busy && bus.start) begin
        r_na    <= bus.a;
        r_nb    <= bus.b;
        r_za    <= '0;
        r_zb    <= '0;
        r_step  <= '0;
        r_exp   <= '0;
        r_ready <= 1'b0;
        r_dz    <= 1'b0;
        r_zero  <= 1'b0;
        if (bus.b == '0) begin
          // Divide-by-zero resolves immediately; nothing to normalize.
          r_dz    <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_busy  <= 1'b1;
          r_state <= NORM;
          r_zero  <= (bus.a == '0);
        end
      end else if (r_state == NORM) begin
        r_na   <= w_na_next;
        r_nb   <= w_nb_next;
        r_za   <= w_za_next;
        r_zb   <= w_zb_next;
        r_step <= r_step + LOGW'(1);
        if (w_last) begin
          // Both counts are within 0..WIDTH-1, so the difference fits EXPW.
          r_exp       <= EXPW'(w_zb_next) - EXPW'(w_za_next);
          r_busy      <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
          r_div_start <= !r_zero;
        end
      end
    end
  end

  assign bus.na        = r_na;
  assign bus.nb        = r_nb;
  assign bus.exp       = r_exp;
  assign bus.busy      = r_busy;
  assign bus.ready     = r_ready;
  assign bus.div_start = r_div_start;
  assign bus.dz        = r_dz;
  assign bus.zero      = r_zero;

endmodule
`default_nettype wire
